// File: rtl/vga_pkg.sv
// ----------------------------------------------------------------------------
// vga_pkg : raster geometry shared by the plot writer and the framebuffer side
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package vga_pkg;

   localparam int RES_W       = 160;
   localparam int RES_H       = 120;
   localparam int FB_DEPTH    = RES_W * RES_H;
   localparam int ADDR_BITS   = 15;
   localparam int COLOUR_BITS = 3;

   typedef logic [ADDR_BITS-1:0] fb_addr_t;

   // y*160 + x computed as (y<<7) + (y<<5) + x; the largest result (19199) fits.
   function automatic fb_addr_t fb_addr(input logic [6:0] y, input logic [7:0] x);
      return {1'b0, y, 7'b0} + {3'b0, y, 5'b0} + {7'b0, x};
   endfunction

endpackage

`default_nettype wire

// File: rtl/plot_fifo.sv
// ----------------------------------------------------------------------------
// plot_fifo : small synchronous FIFO with an occupancy counter for full/empty
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module plot_fifo #(
   parameter int DEPTH     = 4,
   parameter int DATA_BITS = 18
) (
   input  logic                 clock,
   input  logic                 resetn,
   input  logic                 push,
   input  logic                 pop,
   input  logic [DATA_BITS-1:0] din,
   output logic [DATA_BITS-1:0] dout,
   output logic                 full,
   output logic                 empty
);

   localparam int PTR_BITS = $clog2(DEPTH);
   localparam int CNT_BITS = PTR_BITS + 1;

   logic [DATA_BITS-1:0] mem_q [DEPTH];
   logic [PTR_BITS-1:0]  wr_ptr_q, wr_ptr_d;
   logic [PTR_BITS-1:0]  rd_ptr_q, rd_ptr_d;
   logic [CNT_BITS-1:0]  count_q, count_d;
   logic                 do_push;
   logic                 do_pop;

   assign full  = (count_q == CNT_BITS'(DEPTH));
   assign empty = (count_q == '0);
   assign dout  = mem_q[rd_ptr_q];

   // A push into a full FIFO still lands when a pop frees a slot on the same edge.
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   always_ff @(posedge clock) begin
      if (do_push) mem_q[wr_ptr_q] <= din;
   end

endmodule

`default_nettype wire

// File: rtl/plot_receiver.sv
// ----------------------------------------------------------------------------
// plot_receiver : range-checks pixel plots, buffers them and writes the framebuffer
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module plot_receiver #(
   parameter int WIDTH       = 160,
   parameter int HEIGHT      = 120,
   parameter int FIFO_DEPTH  = 4,
   parameter int COLOUR_BITS = 3
) (
   input  logic                   clock,
   input  logic                   resetn,
   input  logic [7:0]             x,
   input  logic [6:0]             y,
   input  logic [COLOUR_BITS-1:0] colour,
   input  logic                   plot,
   input  logic                   mem_grant,
   input  logic                   clear_flags,
   output logic [14:0]            mem_address,
   output logic [COLOUR_BITS-1:0] mem_data,
   output logic                   mem_wren,
   output logic                   busy,
   output logic                   overflow,
   output logic [7:0]             drop_count
);

   import vga_pkg::*;

   localparam int         ENTRY_BITS = ADDR_BITS + COLOUR_BITS;
   localparam logic [8:0] X_LIM      = 9'(WIDTH);
   localparam logic [7:0] Y_LIM      = 8'(HEIGHT);

   logic                   s1_valid_q, s1_valid_d;
   logic [7:0]             s1_x_q, s1_x_d;
   logic [6:0]             s1_y_q, s1_y_d;
   logic [COLOUR_BITS-1:0] s1_colour_q, s1_colour_d;
   logic [14:0]            mem_address_q, mem_address_d;
   logic [COLOUR_BITS-1:0] mem_data_q, mem_data_d;
   logic                   mem_wren_q, mem_wren_d;
   logic                   overflow_q, overflow_d;
   logic [7:0]             drop_count_q, drop_count_d;

   logic                   in_range;
   logic                   drop_event;
   logic                   overflow_event;
   logic                   fifo_push;
   logic                   fifo_pop;
   logic                   fifo_full;
   logic                   fifo_empty;
   logic [ENTRY_BITS-1:0]  fifo_din;
   logic [ENTRY_BITS-1:0]  fifo_dout;

   assign in_range   = ({1'b0, x} < X_LIM) && ({1'b0, y} < Y_LIM);
   assign drop_event = plot && !in_range;

   assign fifo_push      = s1_valid_q;
   assign fifo_din       = {fb_addr(s1_y_q, s1_x_q), s1_colour_q};
   assign fifo_pop       = mem_grant && !fifo_empty;
   assign overflow_event = fifo_push && fifo_full && !fifo_pop;

   plot_fifo #(
      .DEPTH     (FIFO_DEPTH),
      .DATA_BITS (ENTRY_BITS)
   ) u_fifo (
      .clock  (clock),
      .resetn (resetn),
      .push   (fifo_push),
      .pop    (fifo_pop),
      .din    (fifo_din),
      .dout   (fifo_dout),
      .full   (fifo_full),
      .empty  (fifo_empty)
   );

   always_comb begin
      s1_valid_d    = plot && in_range;
      s1_x_d        = s1_x_q;
      s1_y_d        = s1_y_q;
      s1_colour_d   = s1_colour_q;
      mem_wren_d    = fifo_pop;
      mem_address_d = mem_address_q;
      mem_data_d    = mem_data_q;
      overflow_d    = overflow_q;
      drop_count_d  = drop_count_q;

      if (plot) begin
         s1_x_d      = x;
         s1_y_d      = y;
         s1_colour_d = colour;
      end

      if (fifo_pop) begin
         mem_address_d = fifo_dout[ENTRY_BITS-1 -: ADDR_BITS];
         mem_data_d    = fifo_dout[COLOUR_BITS-1:0];
      end

      // Clear applies first so a coincident event survives it.
      if (clear_flags) begin
         overflow_d   = 1'b0;
         drop_count_d = '0;
      end
      if (overflow_event) overflow_d = 1'b1;
      if (drop_event && (drop_count_d != 8'hFF)) drop_count_d = drop_count_d + 1'b1;
   end

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         s1_valid_q    <= 1'b0;
         s1_x_q        <= '0;
         s1_y_q        <= '0;
         s1_colour_q   <= '0;
         mem_address_q <= '0;
         mem_data_q    <= '0;
         mem_wren_q    <= 1'b0;
         overflow_q    <= 1'b0;
         drop_count_q  <= '0;
      end else begin
         s1_valid_q    <= s1_valid_d;
         s1_x_q        <= s1_x_d;
         s1_y_q        <= s1_y_d;
         s1_colour_q   <= s1_colour_d;
         mem_address_q <= mem_address_d;
         mem_data_q    <= mem_data_d;
         mem_wren_q    <= mem_wren_d;
         overflow_q    <= overflow_d;
         drop_count_q  <= drop_count_d;
      end
   end

   assign mem_address = mem_address_q;
   assign mem_data    = mem_data_q;
   assign mem_wren    = mem_wren_q;
   assign overflow    = overflow_q;
   assign drop_count  = drop_count_q;
   assign busy        = s1_valid_q || !fifo_empty;

endmodule

`default_nettype wire
